alu_op_sequencer: RTL and testbench

Command-side sequencer for the 32-bit datapath ALU. It accepts operation requests over a valid/ready handshake and drives the ALU operand and opcode ports from registers. It captures the ALU's combinational `z` and `zero` one cycle later and returns them, tagged, through a buffered valid/ready result port. It sits between the control unit and the ALU: the ALU computes, and this block issues work to it and collects the results.

---
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issues ALU commands from registers and returns tagged results through a small FIFO.
// Optional counters are enabled by defining ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_a,
  input  logic [31:0]     cmd_b,
  input  logic [2:0]      cmd_op,
  input  logic [TAGW-1:0] cmd_tag,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [2:0]      alu_op,
  input  logic [31:0]     alu_z,
  input  logic            alu_zero,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_z,
  output logic            res_zero,
  output logic [TAGW-1:0] res_tag,
`ifdef ALU_SEQ_STATS_EN
  output logic [31:0]     stat_ops,
  output logic [15:0]     stat_err,
  output logic [15:0]     stat_stall,
`endif
  output logic            res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 32 + 1 + TAGW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);
  localparam logic [PW:0]   DEPTH_EXT = (PW+1)'(DEPTH);

  logic            r_issValid;
  logic [TAGW-1:0] r_issTag;
  logic            r_issErr;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [EW-1:0]   r_mem [DEPTH];

  logic [PW-1:0]   w_count;
  logic            w_accept;
  logic            w_pop;
  logic            w_cmdIllegal;
  logic [EW-1:0]   w_wdata;

  assign w_count      = r_wptr - r_rptr;
  assign cmd_ready    = ({1'b0, w_count} + {{PW{1'b0}}, r_issValid}) < DEPTH_EXT;
  assign w_accept     = cmd_valid && cmd_ready;
  assign res_valid    = (w_count != '0);
  assign w_pop        = res_valid && res_ready;
  assign w_cmdIllegal = !(cmd_op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});

  // Illegal commands still travel through the ALU but their result is masked to zero.
  assign w_wdata = r_issErr ? {32'd0, 1'b0, r_issTag, 1'b1}
                            : {alu_z, alu_zero, r_issTag, 1'b0};

  assign {res_z, res_zero, res_tag, res_err} = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issValid <= 1'b0;
      r_issTag   <= '0;
      r_issErr   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else if (w_accept) begin
      r_issValid <= 1'b1;
      r_issTag   <= cmd_tag;
      r_issErr   <= w_cmdIllegal;
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_op     <= cmd_op;
    end else begin
      r_issValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (r_issValid) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)      r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (r_issValid) r_mem[r_wptr[AW-1:0]] <= w_wdata;
  end

  always @(posedge clk) begin
    if (!reset) assert (!(r_issValid && w_count == DEPTH_PTR));
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops   <= '0;
      stat_err   <= '0;
      stat_stall <= '0;
    end else begin
      if (w_accept && stat_ops != '1)                    stat_ops   <= stat_ops + 32'd1;
      if (w_accept && w_cmdIllegal && stat_err != '1)    stat_err   <= stat_err + 16'd1;
      if (cmd_valid && !cmd_ready && stat_stall != '1)   stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU stub on the alu_* ports.
// Stats ports are checked only when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdA;
  logic [31:0] cmdB;
  logic [2:0]  cmdOp;
  logic [3:0]  cmdTag;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [2:0]  aluOp;
  logic [31:0] aluZ;
  logic        aluZero;
  logic        resValid;
  logic        resReady;
  logic [31:0] resZ;
  logic        resZero;
  logic [3:0]  resTag;
  logic        resErr;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0] statOps;
  logic [15:0] statErr;
  logic [15:0] statStall;
`endif

  int testsRun = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(4), .TAGW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_a     (cmdA),
    .cmd_b     (cmdB),
    .cmd_op    (cmdOp),
    .cmd_tag   (cmdTag),
    .alu_a     (aluA),
    .alu_b     (aluB),
    .alu_op    (aluOp),
    .alu_z     (aluZ),
    .alu_zero  (aluZero),
    .res_valid (resValid),
    .res_ready (resReady),
    .res_z     (resZ),
    .res_zero  (resZero),
    .res_tag   (resTag),
`ifdef ALU_SEQ_STATS_EN
    .stat_ops  (statOps),
    .stat_err  (statErr),
    .stat_stall(statStall),
`endif
    .res_err   (resErr)
  );

  // Stand-in ALU; illegal opcodes produce junk so the masking is visible.
  always_comb begin
    aluZ    = 32'hDEAD_BEEF;
    aluZero = 1'b1;
    case (aluOp)
      3'b000: aluZ = aluA & aluB;
      3'b001: aluZ = aluA | aluB;
      3'b010: aluZ = aluA + aluB;
      3'b110: aluZ = aluA - aluB;
      3'b111: aluZ = {31'd0, $signed(aluA) < $signed(aluB)};
      default: aluZ = 32'hDEAD_BEEF;
    endcase
    if (aluOp inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111}) aluZero = (aluZ == 32'd0);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] expZ;
    logic        expZero;
    logic        expErr;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Single command with the consumer stalled until the result is seen; starts and ends on a negedge.
  task automatic applyStimulus(input vec_t v);
    checkOutput("vec cmd_ready idle", 32'(cmdReady), 32'd1);
    cmdValid = 1'b1;
    cmdA     = v.a;
    cmdB     = v.b;
    cmdOp    = v.op;
    cmdTag   = v.tag;
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput("vec alu_op", 32'(aluOp), 32'(v.op));
    checkOutput("vec alu_a", aluA, v.a);
    checkOutput("vec res_valid early", 32'(resValid), 32'd0);
    @(negedge clk);
    checkOutput("vec res_valid", 32'(resValid), 32'd1);
    checkOutput("vec res_z", resZ, v.expZ);
    checkOutput("vec res_zero", 32'(resZero), 32'(v.expZero));
    checkOutput("vec res_tag", 32'(resTag), 32'(v.tag));
    checkOutput("vec res_err", 32'(resErr), 32'(v.expErr));
    resReady = 1'b1;
    @(negedge clk);
    resReady = 1'b0;
    checkOutput("vec res_valid after pop", 32'(resValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts;
    int got;

    vecs[0] = '{3'b010, 32'd5,          32'd7,      4'd3, 32'd12,         1'b0, 1'b0};
    vecs[1] = '{3'b110, 32'd9,          32'd9,      4'd4, 32'd0,          1'b1, 1'b0};
    vecs[2] = '{3'b111, 32'hFFFF_FFFF,  32'd1,      4'd5, 32'd1,          1'b0, 1'b0};
    vecs[3] = '{3'b111, 32'd5,          32'd3,      4'd6, 32'd0,          1'b1, 1'b0};
    vecs[4] = '{3'b000, 32'h0000_F0F0,  32'h0000_FF00, 4'd7, 32'h0000_F000, 1'b0, 1'b0};
    vecs[5] = '{3'b001, 32'h0000_000F,  32'h0000_00F0, 4'd8, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[6] = '{3'b110, 32'd3,          32'd5,      4'd1, 32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[7] = '{3'b100, 32'd5,          32'd7,      4'd9, 32'd0,          1'b0, 1'b1};
    vecs[8] = '{3'b011, 32'd0,          32'd0,      4'd2, 32'd0,          1'b0, 1'b1};

    reset    = 1'b1;
    cmdValid = 1'b0;
    cmdA     = '0;
    cmdB     = '0;
    cmdOp    = '0;
    cmdTag   = '0;
    resReady = 1'b0;
    #12;
    checkOutput("reset res_valid", 32'(resValid), 32'd0);
    checkOutput("reset cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("reset alu_op", 32'(aluOp), 32'd0);
    checkOutput("reset alu_b", aluB, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);
`ifdef ALU_SEQ_STATS_EN
    checkOutput("stat_ops", statOps, 32'd9);
    checkOutput("stat_err", 32'(statErr), 32'd2);
`endif

    // Back-to-back commands with the consumer always ready.
    $display("[TB] streaming");
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      resReady = 1'b1;
      if (j >= 2 && j <= 9) begin
        checkOutput("stream res_valid", 32'(resValid), 32'd1);
        checkOutput("stream res_tag", 32'(resTag), 32'(j - 2));
        checkOutput("stream res_z", resZ, 32'(j - 2 + 100));
      end else begin
        checkOutput("stream res_valid idle", 32'(resValid), 32'd0);
      end
      if (j < 8) begin
        checkOutput("stream cmd_ready", 32'(cmdReady), 32'd1);
        cmdValid = 1'b1;
        cmdOp    = 3'b010;
        cmdA     = 32'(j);
        cmdB     = 32'd100;
        cmdTag   = 4'(j);
      end else begin
        cmdValid = 1'b0;
      end
    end
    resReady = 1'b0;

    // Consumer stalled: the FIFO plus issue stage must throttle at DEPTH accepts.
    $display("[TB] backpressure");
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmdValid = 1'b1;
      cmdOp    = 3'b010;
      cmdA     = 32'd1;
      cmdB     = 32'd1;
      cmdTag   = 4'(accepts);
      if (cmdReady) accepts++;
    end
    @(negedge clk);
    checkOutput("bp accepts", 32'(accepts), 32'd4);
    checkOutput("bp cmd_ready low", 32'(cmdReady), 32'd0);
    checkOutput("bp res_valid", 32'(resValid), 32'd1);
    resReady = 1'b1;
    @(negedge clk);
    resReady = 1'b0;
    checkOutput("bp cmd_ready after pop", 32'(cmdReady), 32'd1);
    for (int c = 0; c < 6; c++) begin
      cmdTag = 4'(accepts);
      if (cmdReady) accepts++;
      @(negedge clk);
    end
    cmdValid = 1'b0;
    checkOutput("bp accepts after one pop", 32'(accepts), 32'd5);
    got = 1;
    resReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (resValid) begin
        checkOutput("bp drain tag", 32'(resTag), 32'(got));
        checkOutput("bp drain z", resZ, 32'd2);
        got++;
      end
      @(negedge clk);
    end
    resReady = 1'b0;
    checkOutput("bp drain count", 32'(got), 32'd5);

    // Three results buffered and one in flight, then an asynchronous reset.
    $display("[TB] reset mid-operation");
    for (int c = 0; c < 4; c++) begin
      cmdValid = 1'b1;
      cmdOp    = 3'b001;
      cmdA     = 32'h55;
      cmdB     = 32'hAA;
      cmdTag   = 4'(c + 10);
      @(negedge clk);
    end
    cmdValid = 1'b0;
    checkOutput("mid res_valid before reset", 32'(resValid), 32'd1);
    checkOutput("mid cmd_ready before reset", 32'(cmdReady), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid res_valid in reset", 32'(resValid), 32'd0);
    checkOutput("mid cmd_ready in reset", 32'(cmdReady), 32'd1);
    checkOutput("mid alu_a in reset", aluA, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post reset res_valid", 32'(resValid), 32'd0);
    end
    resReady = 1'b0;
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule
